// File: rtl/text_writer.sv
// text_writer: turns an ASCII byte stream into writes to a character text buffer.
//
// Printable bytes are written at the cursor, which then advances. It wraps at the
// end of a row and at the bottom of the screen; there is no scrolling.
// CR, LF and BS move the cursor. BS also blanks the cell it moves onto.
// FF blanks the whole screen, one cell per cycle, and then homes the cursor.
// Every other byte is accepted and dropped.
//
// Parameters
//   NCOL      number of character columns (at most 128)
//   NROW      number of character rows (at most 32)
// Ports
//   clk       system/pixel clock, rising edge
//   rstn      asynchronous active-low reset
//   in_valid  byte on in_data is offered
//   in_data   ASCII byte
//   in_ready  a byte can be taken this cycle (low while clearing)
//   wr_en     one-cycle write strobe to the text buffer
//   col_w     column of the cell being written
//   row_w     row of the cell being written
//   din       ASCII code written to the cell
//   cur_col   cursor column
//   cur_row   cursor row
//   busy      screen clear in progress
module text_writer #(
   parameter int NCOL = 80,
   parameter int NROW = 30
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       wr_en,
   output logic [6:0] col_w,
   output logic [4:0] row_w,
   output logic [6:0] din,
   output logic [6:0] cur_col,
   output logic [4:0] cur_row,
   output logic       busy
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [6:0] COL_LAST = 7'(NCOL - 1);
   localparam logic [4:0] ROW_LAST = 5'(NROW - 1);
   localparam logic [6:0] SPACE    = 7'h20;
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;

   state_t     state, state_nxt;
   logic       wr_en_nxt;
   logic [6:0] col_w_nxt, din_nxt, cur_col_nxt;
   logic [4:0] row_w_nxt, cur_row_nxt;
   logic       accept;

   function automatic logic [4:0] row_inc(input logic [4:0] r);
      return (r == ROW_LAST) ? 5'd0 : r + 5'd1;
   endfunction

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

   assign in_ready = (state == IDLE);
   assign busy     = (state == CLEAR);
   assign accept   = in_valid && (state == IDLE);

   always_comb begin
      state_nxt   = state;
      wr_en_nxt   = 1'b0;
      col_w_nxt   = col_w;
      row_w_nxt   = row_w;
      din_nxt     = din;
      cur_col_nxt = cur_col;
      cur_row_nxt = cur_row;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_printable(in_data)) begin
                  wr_en_nxt = 1'b1;
                  col_w_nxt = cur_col;
                  row_w_nxt = cur_row;
                  din_nxt   = in_data[6:0];
                  if (cur_col == COL_LAST) begin
                     cur_col_nxt = 7'd0;
                     cur_row_nxt = row_inc(cur_row);
                  end else begin
                     cur_col_nxt = cur_col + 7'd1;
                  end
               end else begin
                  case (in_data)
                     CH_CR: cur_col_nxt = 7'd0;
                     CH_LF: cur_row_nxt = row_inc(cur_row);
                     CH_BS: begin
                        if (cur_col != 7'd0) begin
                           cur_col_nxt = cur_col - 7'd1;
                           wr_en_nxt   = 1'b1;
                           col_w_nxt   = cur_col - 7'd1;
                           row_w_nxt   = cur_row;
                           din_nxt     = SPACE;
                        end
                     end
                     CH_FF: begin
                        // Cell (0,0) is written on the accepting edge itself.
                        state_nxt = CLEAR;
                        wr_en_nxt = 1'b1;
                        col_w_nxt = 7'd0;
                        row_w_nxt = 5'd0;
                        din_nxt   = SPACE;
                     end
                     default: ;
                  endcase
               end
            end
         end
         CLEAR: begin
            // col_w/row_w double as the sweep counter. Once the last cell is
            // on the outputs, the clear ends and the cursor returns home.
            if (col_w == COL_LAST && row_w == ROW_LAST) begin
               state_nxt   = IDLE;
               cur_col_nxt = 7'd0;
               cur_row_nxt = 5'd0;
            end else begin
               wr_en_nxt = 1'b1;
               din_nxt   = SPACE;
               if (col_w == COL_LAST) begin
                  col_w_nxt = 7'd0;
                  row_w_nxt = row_w + 5'd1;
               end else begin
                  col_w_nxt = col_w + 7'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         wr_en   <= 1'b0;
         col_w   <= 7'd0;
         row_w   <= 5'd0;
         din     <= 7'd0;
         cur_col <= 7'd0;
         cur_row <= 5'd0;
      end else begin
         state   <= state_nxt;
         wr_en   <= wr_en_nxt;
         col_w   <= col_w_nxt;
         row_w   <= row_w_nxt;
         din     <= din_nxt;
         cur_col <= cur_col_nxt;
         cur_row <= cur_row_nxt;
      end
   end

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer. It keeps its own cursor model and pushes every
// expected cell write into a queue. A monitor on the falling edge pops one entry
// for each wr_en pulse it sees. Any write with no entry waiting is an error.
module tb_text_writer;

   localparam int NCOL = 80;
   localparam int NROW = 30;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready, wr_en, busy;
   logic [6:0] col_w, din, cur_col;
   logic [4:0] row_w, cur_row;

   typedef struct packed {
      logic [6:0] c;
      logic [4:0] r;
      logic [6:0] d;
   } wr_t;

   wr_t sb[$];
   int  total = 0;
   int  bad = 0;
   int  mcol = 0;
   int  mrow = 0;

   text_writer #(.NCOL(NCOL), .NROW(NROW)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .col_w(col_w), .row_w(row_w),
      .din(din), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
   );

   always #5 clk = ~clk;

   // Monitor: every write must match the oldest expected entry.
   always @(negedge clk) begin
      if (rstn && wr_en) begin
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_write observed col=%0d row=%0d din=%h expected none", col_w, row_w, din);
         end
         if (sb.size() != 0) begin
            wr_t e;
            wr_t o;
            e = sb.pop_front();
            o = '{c: col_w, r: row_w, d: din};
            total++;
            assert (o === e) else begin
               bad++;
               $error("FAIL write observed col=%0d row=%0d din=%h expected col=%0d row=%0d din=%h",
                      o.c, o.r, o.d, e.c, e.r, e.d);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cur(input string tag, input int c, input int r);
      check({tag, "_col"}, 32'(cur_col), 32'(c));
      check({tag, "_row"}, 32'(cur_row), 32'(r));
   endtask

   // Reference behaviour for one accepted byte.
   task automatic model_byte(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         sb.push_back('{c: 7'(mcol), r: 5'(mrow), d: b[6:0]});
         mcol++;
         if (mcol == NCOL) begin
            mcol = 0;
            mrow = (mrow + 1) % NROW;
         end
      end else if (b == 8'h0D) begin
         mcol = 0;
      end else if (b == 8'h0A) begin
         mrow = (mrow + 1) % NROW;
      end else if (b == 8'h08) begin
         if (mcol > 0) begin
            mcol--;
            sb.push_back('{c: 7'(mcol), r: 5'(mrow), d: 7'h20});
         end
      end else if (b == 8'h0C) begin
         for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++)
               sb.push_back('{c: 7'(c), r: 5'(r), d: 7'h20});
         mcol = 0;
         mrow = 0;
      end
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic [7:0] b);
      int n = 0;
      while (!in_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (n < 5000) else begin
         bad++;
         $error("FAIL ready_timeout observed=%0d expected<5000", n);
      end
      in_valid = 1'b1;
      in_data  = b;
      model_byte(b);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   initial begin
      int n;
      logic [7:0] junk [4];
      junk = '{8'h00, 8'h7F, 8'h85, 8'h1B};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_outs", {13'd0, col_w, row_w, din}, 32'd0);
      check_cur("rst_cur", 0, 0);
      rstn = 1'b1;

      // Single printable
      send(8'h41);
      check("a_wr_en", 32'(wr_en), 32'd1);
      check_cur("a_cur", 1, 0);

      // Discarded bytes: no write, no movement
      foreach (junk[i]) send(junk[i]);
      check_cur("junk_cur", 1, 0);

      // Move to (5,3), then CR+LF
      repeat (3) send(8'h0A);
      send(8'h0D);
      for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
      check_cur("pos53", 5, 3);
      send(8'h0D);
      send(8'h0A);
      check("crlf_wr_en", 32'(wr_en), 32'd0);
      check_cur("crlf_cur", 0, 4);

      // Backspace at column 0, then mid-row; the LF loop also covers row wrap
      repeat (28) send(8'h0A);
      check_cur("lfwrap_cur", 0, 2);
      send(8'h08);
      check("bs0_wr_en", 32'(wr_en), 32'd0);
      check_cur("bs0_cur", 0, 2);
      send(8'h61); send(8'h62); send(8'h63);
      check_cur("bs3_pre", 3, 2);
      send(8'h08);
      check_cur("bs3_cur", 2, 2);

      // Form feed with in_valid held high throughout the clear
      in_valid = 1'b1;
      in_data  = 8'h0C;
      model_byte(8'h0C);
      @(negedge clk);
      in_data = 8'h51;
      check("ff_busy", 32'(busy), 32'd1);
      n = 0;
      while (!in_ready && n < 3000) begin
         n++;
         @(negedge clk);
      end
      check("ff_ready_low_cycles", 32'(n), 32'd2400);
      check("ff_busy_end", 32'(busy), 32'd0);
      check_cur("ff_cur", 0, 0);
      check("ff_sb_empty", 32'(sb.size()), 32'd0);
      model_byte(8'h51);
      @(negedge clk);
      in_valid = 1'b0;
      check_cur("ff_next_cur", 1, 0);

      // Fill to the last cell, then wrap to home
      for (int i = 0; i < 2398; i++) send(8'h78);
      check_cur("last_cell", 79, 29);
      send(8'h5A);
      check_cur("wrap_cur", 0, 0);

      // Reset in the middle of a clear
      send(8'h0C);
      repeat (100) @(negedge clk);
      #2 rstn = 1'b0;
      sb.delete();
      mcol = 0;
      mrow = 0;
      #1;
      check("midrst_wr_en", 32'(wr_en), 32'd0);
      check("midrst_outs", {13'd0, col_w, row_w, din}, 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (50) @(negedge clk);
      check_cur("postrst_cur", 0, 0);
      check("postrst_ready", 32'(in_ready), 32'd1);
      send(8'h42);
      check_cur("postrst_b_cur", 1, 0);
      @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
